// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning HI/LO: 32-step shift-add multiply
// and restoring divide on operand magnitudes, with a one-cycle sign fixup.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

   state_t      state_reg;
   logic [4:0]  count_reg;
   logic [63:0] prod_reg;      // mul: {partial sum, multiplier}; div: [31:0] dividend/quotient
   logic [31:0] rem_reg;
   logic [31:0] opnd_reg;      // multiplicand magnitude or divisor magnitude
   logic        neg_a_reg;
   logic        neg_b_reg;
   logic        is_div_reg;
   logic        div_zero_reg;
   logic        done_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_fits;
   logic [63:0] prod_neg;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg     = is_signed & operand_a[31];
   assign b_neg     = is_signed & operand_b[31];
   assign a_mag     = a_neg ? (32'd0 - operand_a) : operand_a;
   assign b_mag     = b_neg ? (32'd0 - operand_b) : operand_b;

   assign mul_sum   = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, opnd_reg} : 33'd0);

   // Partial remainder stays below 2*divisor, so a 33-bit borrow decides the step.
   assign div_shift = {rem_reg, prod_reg[31]};
   assign div_diff  = div_shift - {1'b0, opnd_reg};
   assign div_fits  = ~div_diff[32];

   assign prod_neg  = 64'd0 - prod_reg;
   assign quot_fix  = div_zero_reg ? 32'hFFFF_FFFF :
                      ((neg_a_reg ^ neg_b_reg) ? (32'd0 - prod_reg[31:0]) : prod_reg[31:0]);
   assign rem_fix   = neg_a_reg ? (32'd0 - rem_reg) : rem_reg;

   assign busy = (state_reg != IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= 5'd0;
         prod_reg     <= 64'd0;
         rem_reg      <= 32'd0;
         opnd_reg     <= 32'd0;
         neg_a_reg    <= 1'b0;
         neg_b_reg    <= 1'b0;
         is_div_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
         done_reg     <= 1'b0;
         hi_reg       <= 32'd0;
         lo_reg       <= 32'd0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        neg_a_reg  <= a_neg;
                        neg_b_reg  <= b_neg;
                        is_div_reg <= 1'b0;
                        opnd_reg   <= a_mag;
                        prod_reg   <= {32'd0, b_mag};
                        count_reg  <= 5'd0;
                        state_reg  <= MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        neg_a_reg    <= a_neg;
                        neg_b_reg    <= b_neg;
                        is_div_reg   <= 1'b1;
                        div_zero_reg <= (operand_b == 32'd0);
                        opnd_reg     <= b_mag;
                        prod_reg     <= {32'd0, a_mag};
                        rem_reg      <= 32'd0;
                        count_reg    <= 5'd0;
                        state_reg    <= DIV;
                     end
                     OP_MTHI: hi_reg <= operand_a;
                     OP_MTLO: lo_reg <= operand_a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               prod_reg  <= {mul_sum, prod_reg[31:1]};
               count_reg <= count_reg + 5'd1;
               if (count_reg == 5'd31) state_reg <= FIXUP;
            end
            DIV: begin
               rem_reg        <= div_fits ? div_diff[31:0] : div_shift[31:0];
               prod_reg[31:0] <= {prod_reg[30:0], div_fits};
               count_reg      <= count_reg + 5'd1;
               if (count_reg == 5'd31) state_reg <= FIXUP;
            end
            FIXUP: begin
               if (is_div_reg) begin
                  lo_reg <= quot_fix;
                  hi_reg <= rem_fix;
               end else if (neg_a_reg ^ neg_b_reg) begin
                  {hi_reg, lo_reg} <= prod_neg;
               end else begin
                  {hi_reg, lo_reg} <= prod_reg;
               end
               done_reg  <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic
// reference model of HI/LO results and cycle timing.
module tb_muldiv_sequencer;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int miscompares = 0;

   muldiv_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      sq;
      longint      sr;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      res = 64'd0;
      case (o)
         OP_MULTU: res = ua * ub;
         OP_MULT:  res = 64'(sa * sb);
         OP_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
         OP_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   // Issue one mult/div, optionally pulsing a second start at negedge index inj_at.
   task automatic do_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input logic [5:0] inj_op, input logic [31:0] inj_a,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int busy_n, output int done_n, output int done_idx);
      busy_n   = 0;
      done_n   = 0;
      done_idx = -1;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(negedge clk);
      for (int idx = 1; idx <= 45; idx++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_idx = idx;
         end
         if (idx == inj_at) begin
            start = 1'b1; op = inj_op; operand_a = inj_a; operand_b = $urandom;
         end else begin
            start = 1'b0; op = 6'd0; operand_a = $urandom; operand_b = $urandom;
         end
         @(negedge clk);
      end
      rh = hi;
      rl = lo;
   endtask

   task automatic check_op(input string name, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int inj_at, input logic [5:0] inj_op, input logic [31:0] inj_a);
      logic [31:0] rh;
      logic [31:0] rl;
      int          bn;
      int          dn;
      int          di;
      do_op(o, a, b, inj_at, inj_op, inj_a, rh, rl, bn, dn, di);
      $display("%s op=%b a=%h b=%h hi=%h lo=%h busy_cycles=%0d done_at=%0d",
               name, o, a, b, rh, rl, bn, di);
      vectors++;
      if (rh !== exp[63:32]) begin
         miscompares++;
         $display("FAIL %s hi: got %h expected %h", name, rh, exp[63:32]);
      end
      vectors++;
      if (rl !== exp[31:0]) begin
         miscompares++;
         $display("FAIL %s lo: got %h expected %h", name, rl, exp[31:0]);
      end
      vectors++;
      if (bn !== 33) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d expected 33", name, bn);
      end
      vectors++;
      if (dn !== 1 || di !== 34) begin
         miscompares++;
         $display("FAIL %s done_pulse: got count %0d at %0d expected 1 at 34", name, dn, di);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 6'd0; operand_a = 32'd0; operand_b = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo;
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; operand_a = 32'hDEAD_BEEF;
      @(negedge clk);
      vectors++;
      if (hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL mthi: got hi=%h busy=%b done=%b expected deadbeef 0 0", hi, busy, done);
      end
      op = OP_MTLO; operand_a = 32'hCAFE_F00D;
      @(negedge clk);
      start = 1'b0; op = 6'd0;
      vectors++;
      if (lo !== 32'hCAFE_F00D || hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected deadbeef cafef00d 0 0",
                  hi, lo, busy, done);
      end
      $display("mthi/mtlo hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_reset_mid_op;
      int late_done;
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; operand_a = 32'd5;
      @(negedge clk);
      op = OP_MTLO; operand_a = 32'd6;
      @(negedge clk);
      op = OP_MULT; operand_a = 32'd1234; operand_b = 32'd5678;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (hi !== 32'd5 || lo !== 32'd6 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL preload: got hi=%h lo=%h busy=%b expected 5 6 1", hi, lo, busy);
      end
      repeat (9) @(negedge clk);
      reset = 1'b1;
      start = 1'b1; op = OP_MULTU;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_op: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
      end
      late_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) late_done++;
      end
      vectors++;
      if (late_done !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_no_late_done: got %0d active cycles hi=%h lo=%h expected 0 0 0", late_done, hi, lo);
      end
      $display("reset mid-op busy=%b hi=%h lo=%h", busy, hi, lo);
   endtask

   task automatic test_directed;
      check_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 6'd0, 32'd0);
      check_op("mult_m1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 6'd0, 32'd0);
      check_op("mult_neg7", OP_MULT,  32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB, 0, 6'd0, 32'd0);
      check_op("div_neg7",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0, 6'd0, 32'd0);
      check_op("divu_7",    OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 0, 6'd0, 32'd0);
      check_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 6'd0, 32'd0);
   endtask

   task automatic test_divzero_ignored_start;
      check_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 10, OP_MULT, 32'd99);
      check_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 0, 6'd0, 32'd0);
      check_op("mthi_busy", OP_MULTU, 32'd1000, 32'd3000, 64'd3000000, 5, OP_MTHI, 32'h1111_1111);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'd1;
         4: v = $urandom_range(0, 255);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic test_random;
      logic [5:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: o = OP_MULT;
            1: o = OP_MULTU;
            2: o = OP_DIV;
            default: o = OP_DIVU;
         endcase
         a = pick_operand();
         b = pick_operand();
         check_op("random", o, a, b, model(o, a, b), 0, 6'd0, 32'd0);
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_reset_mid_op();
      test_directed();
      test_divzero_ignored_start();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
